ifu_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the architectural fetch PC and drives an AXI-lite-style read channel (AR/R) to instruction memory. It hands one instruction at a time to decode/execute over a valid/ready handshake. It takes redirects (taken branch, jal/jalr, ecall/mret target) from the PC-next logic and sequences them safely around in-flight bus transactions. It sits between the PC-next logic and the instruction memory interface, and turns the single-cycle PC register into a multi-cycle, stall-aware fetch.

---
 rtl/ifu_fetch_ctrl_pkg.sv | 15 +
 rtl/ifu_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared widths, reset PC, bus response codes and fetch FSM encoding for the IFU fetch sequencer.
package ifu_fetch_ctrl_pkg;

    localparam int unsigned IFU_CPU_WIDTH = 32;
    localparam logic [31:0] IFU_RESET_PC  = 32'h8000_0000;
    localparam logic [1:0]  RRESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_OUT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one AR/R read at a time and
// hands each instruction to decode over valid/ready, absorbing redirects around in-flight reads.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int unsigned          CPU_WIDTH = IFU_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(IFU_RESET_PC)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_redir,
    input  logic [CPU_WIDTH-1:0] i_redir_pc,
    output logic [CPU_WIDTH-1:0] o_pc,
    output logic                 o_arvalid,
    output logic [CPU_WIDTH-1:0] o_araddr,
    input  logic                 i_arready,
    input  logic                 i_rvalid,
    input  logic [CPU_WIDTH-1:0] i_rdata,
    input  logic [1:0]           i_rresp,
    output logic                 o_rready,
    output logic                 o_inst_valid,
    output logic [CPU_WIDTH-1:0] o_inst,
    output logic [CPU_WIDTH-1:0] o_inst_pc,
    output logic                 o_inst_err,
    input  logic                 i_inst_ready
);

    localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);

    fetch_state_e         state_q,      state_d;
    logic [CPU_WIDTH-1:0] pc_q,         pc_d;
    logic [CPU_WIDTH-1:0] pend_pc_q,    pend_pc_d;
    logic                 kill_q,       kill_d;
    logic [CPU_WIDTH-1:0] inst_q,       inst_d;
    logic [CPU_WIDTH-1:0] inst_pc_q,    inst_pc_d;
    logic                 inst_err_q,   inst_err_d;
    logic                 arvalid_q,    arvalid_d;
    logic                 rready_q,     rready_d;
    logic                 inst_valid_q, inst_valid_d;
    logic [CPU_WIDTH-1:0] redir_tgt;

    // Redirect targets are always word aligned.
    assign redir_tgt = {i_redir_pc[CPU_WIDTH-1:2], 2'b00};

    // Next-state, PC sequencing and instruction capture.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        kill_d     = kill_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                // The address already offered must complete; remember where to go after it.
                if (i_redir) begin
                    kill_d    = 1'b1;
                    pend_pc_d = redir_tgt;
                end
                if (i_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_redir) begin
                    kill_d    = 1'b1;
                    pend_pc_d = redir_tgt;
                end
                if (i_rvalid) begin
                    if (kill_q || i_redir) begin
                        pc_d    = i_redir ? redir_tgt : pend_pc_q;
                        kill_d  = 1'b0;
                        state_d = ST_ADDR;
                    end else begin
                        inst_d     = i_rdata;
                        inst_pc_d  = pc_q;
                        inst_err_d = (i_rresp != RRESP_OKAY);
                        state_d    = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                // Retire (redirect belongs to the retiring instruction) or flush the held one.
                if (i_inst_ready || i_redir) begin
                    pc_d    = i_redir ? redir_tgt : pc_q + PC_STEP;
                    state_d = ST_ADDR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        arvalid_d    = (state_d == ST_ADDR);
        rready_d     = (state_d == ST_DATA);
        inst_valid_d = (state_d == ST_OUT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            kill_q       <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_err_q   <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            kill_q       <= kill_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_err_q   <= inst_err_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign o_pc         = pc_q;
    assign o_araddr     = pc_q;
    assign o_arvalid    = arvalid_q;
    assign o_rready     = rready_q;
    assign o_inst_valid = inst_valid_q;
    assign o_inst       = inst_q;
    assign o_inst_pc    = inst_pc_q;
    assign o_inst_err   = inst_err_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized scoreboard bench for ifu_fetch_ctrl: a transaction-level model predicts fetch
// addresses and delivered instructions, a separate monitor checks what decode receives.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          NCYC   = 3000;

    logic        clk = 1'b0;
    logic        i_rst, i_redir, i_arready, i_rvalid, i_inst_ready;
    logic [31:0] i_redir_pc, i_rdata;
    logic [1:0]  i_rresp;
    logic [31:0] o_pc, o_araddr, o_inst, o_inst_pc;
    logic        o_arvalid, o_rready, o_inst_valid, o_inst_err;

    ifu_fetch_ctrl dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_redir      (i_redir),
        .i_redir_pc   (i_redir_pc),
        .o_pc         (o_pc),
        .o_arvalid    (o_arvalid),
        .o_araddr     (o_araddr),
        .i_arready    (i_arready),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .o_rready     (o_rready),
        .o_inst_valid (o_inst_valid),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .o_inst_err   (o_inst_err),
        .i_inst_ready (i_inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic fast_mode = 1'b1;

    // Model state: what the next fetch address must be and what happened in this fetch's life.
    logic [31:0] exp_addr, cur_addr, life_tgt;
    logic        started, in_ar, outstanding, life_redir;
    int          since_rst, idle;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        exp_addr    = RST_PC;
        cur_addr    = '0;
        life_tgt    = '0;
        started     = 1'b0;
        in_ar       = 1'b0;
        outstanding = 1'b0;
        life_redir  = 1'b0;
        idle        = 0;
        sb.delete();
    endtask

    // Hold reset for two edges, check reset values, then release with an IDLE-cycle redirect that must be ignored.
    task automatic do_reset();
        i_rst = 1'b1; i_redir = 1'b0; i_arready = 1'b0; i_rvalid = 1'b0; i_inst_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pc",         o_pc,                RST_PC);
        chk("rst_araddr",     o_araddr,            RST_PC);
        chk("rst_arvalid",    32'(o_arvalid),      32'd0);
        chk("rst_rready",     32'(o_rready),       32'd0);
        chk("rst_inst_valid", 32'(o_inst_valid),   32'd0);
        chk("rst_inst_err",   32'(o_inst_err),     32'd0);
        chk("rst_inst",       o_inst,              32'd0);
        chk("rst_inst_pc",    o_inst_pc,           32'd0);
        @(posedge clk); #1;
        model_reset();
        since_rst  = 0;
        fast_mode  = 1'b1;
        i_rst      = 1'b0;
        i_redir    = 1'b1;
        i_redir_pc = 32'h1234_5677;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Stimulus: memory responder, decode readiness and redirects, plus the reference model.
    initial begin : stim
        logic reset_done;
        int   k;
        reset_done = 1'b0;
        i_rst = 1'b1; i_redir = 1'b0; i_redir_pc = '0; i_arready = 1'b0;
        i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00; i_inst_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (!reset_done && cyc > NCYC / 2 && outstanding) begin
                reset_done = 1'b1;
                do_reset();
            end
            fast_mode    = (since_rst < 15);
            i_arready    = fast_mode ? 1'b1 : ($urandom_range(0, 2) == 0);
            i_rvalid     = outstanding && (fast_mode || $urandom_range(0, 2) == 0);
            i_rdata      = i_rvalid ? mem_word(cur_addr) : $urandom;
            k            = int'($urandom_range(0, 7));
            i_rresp      = (fast_mode || k > 2) ? 2'b00 : (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b11;
            i_inst_ready = fast_mode ? 1'b1 : ($urandom_range(0, 1) == 1);
            i_redir      = !fast_mode && ($urandom_range(0, 5) == 0);
            k            = int'($urandom_range(0, 3));
            i_redir_pc   = (k == 0) ? 32'h8000_0103 : (k == 1) ? 32'h8000_0200 :
                           (k == 2) ? 32'hFFFF_FFFB : $urandom;

            @(negedge clk);
            idle++;
            if (o_arvalid) begin
                started = 1'b1;
                chk("ar_while_outstanding", 32'(outstanding), 32'd0);
                if (!in_ar) begin
                    in_ar      = 1'b1;
                    cur_addr   = o_araddr;
                    life_redir = 1'b0;
                    chk("araddr", o_araddr, exp_addr);
                end else begin
                    chk("araddr_stable", o_araddr, cur_addr);
                end
            end else if (in_ar) begin
                chk("arvalid_withdrawn", 32'(o_arvalid), 32'd1);
                in_ar = 1'b0;
            end
            if (i_redir && started) begin
                life_redir = 1'b1;
                life_tgt   = align(i_redir_pc);
            end
            if (o_arvalid && i_arready) begin
                in_ar       = 1'b0;
                outstanding = 1'b1;
                idle        = 0;
            end
            if (i_rvalid && o_rready) begin
                outstanding = 1'b0;
                idle        = 0;
                if (life_redir) exp_addr = life_tgt;
                else            sb.push_back('{inst: i_rdata, pc: cur_addr, err: (i_rresp != 2'b00)});
            end
            if (o_inst_valid && (i_inst_ready || i_redir)) begin
                exp_addr = i_redir ? align(i_redir_pc) : cur_addr + 32'd4;
                idle     = 0;
            end
            if (idle > 100) begin
                chk("watchdog_progress", 32'(idle), 32'd0);
                break;
            end
            since_rst++;
            @(posedge clk); #1;
        end
        i_redir = 1'b0; i_arready = 1'b0; i_rvalid = 1'b0; i_inst_ready = 1'b0;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: compares each instruction presented to decode against the scoreboard.
    initial begin : mon
        exp_t cur;
        logic holding, was_done;
        int   mcyc, last_pres;
        holding = 1'b0; was_done = 1'b0; mcyc = 0; last_pres = -1;
        cur = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (i_rst) begin
                holding = 1'b0; was_done = 1'b0; last_pres = -1;
                continue;
            end
            if (was_done) chk("inst_valid_fall", 32'(o_inst_valid), 32'd0);
            if (o_inst_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        chk("inst_unexpected", 32'(o_inst_valid), 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        chk("inst",     o_inst,          cur.inst);
                        chk("inst_pc",  o_inst_pc,       cur.pc);
                        chk("inst_err", 32'(o_inst_err), 32'(cur.err));
                    end
                    if (fast_mode && last_pres >= 0) chk("fetch_period", 32'(mcyc - last_pres), 32'd3);
                    last_pres = fast_mode ? mcyc : -1;
                end else begin
                    chk("inst_stable",     o_inst,          cur.inst);
                    chk("inst_pc_stable",  o_inst_pc,       cur.pc);
                    chk("inst_err_stable", 32'(o_inst_err), 32'(cur.err));
                end
            end
            if (!fast_mode) last_pres = -1;
            was_done = o_inst_valid && (i_inst_ready || i_redir);
            holding  = o_inst_valid && !was_done;
        end
    end

endmodule
